operand2_loader: RTL and testbench

Writable operand-2 store for the calculator datapath: it accepts operand words as a stream of bytes over a valid/ready handshake, assembles them into 16-bit words and writes them to sequential addresses of a 16-entry array. Its read side has the same address-in / registered-value-out interface the ALU front end already uses, so operand 2 can be loaded at run time instead of fixed at elaboration. It also provides a pointer-set command and a multi-cycle bulk clear.

---
 rtl/operand2_loader.sv | 128 ++++++++++++
 tb/tb_operand2_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand2_loader.sv
// Run-time loadable operand-2 store: bytes stream in over valid/ready, pair into 16-bit words,
// and land at sequential addresses; registered read port plus pointer-set and bulk clear.
module operand2_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  input  logic [3:0]        start_addr,
  input  logic              clear,
  output logic              busy,
  output logic              word_done,
  output logic [4:0]        wr_count,
  input  logic [3:0]        operand2_addr,
  output logic [DATA_W-1:0] operand2_value
);

  typedef enum logic [1:0] {StHi, StLo, StClr} state_e;

  localparam logic [3:0] LastIdx = 4'(DEPTH - 1);
  localparam logic [4:0] CntMax  = 5'(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [7:0]        hi_q, hi_d;
  logic [3:0]        clr_idx_q, clr_idx_d;
  logic [4:0]        wr_count_q, wr_count_d;
  logic              word_done_q, word_done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [3:0]        mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              accept;

  assign in_ready       = (state_q != StClr) && !start && !clear;
  assign accept         = in_valid && in_ready;
  assign busy           = (state_q == StClr);
  assign word_done      = word_done_q;
  assign wr_count       = wr_count_q;
  assign operand2_value = rd_data_q;

  // Read samples the pre-edge array, so a same-edge write returns the old word.
  assign rd_data_d = mem_q[operand2_addr];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hi_d        = hi_q;
    clr_idx_d   = clr_idx_q;
    wr_count_d  = wr_count_q;
    word_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = {hi_q, in_byte};

    case (state_q)
      StClr: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 4'd1;
        if (clr_idx_q == LastIdx) begin
          state_d    = StHi;
          ptr_d      = '0;
          wr_count_d = '0;
          clr_idx_d  = '0;
        end
      end
      StHi, StLo: begin
        if (clear) begin
          state_d   = StClr;
          clr_idx_d = '0;
        end else if (start) begin
          ptr_d      = start_addr;
          wr_count_d = '0;
          state_d    = StHi;
        end else if (accept) begin
          if (state_q == StHi) begin
            hi_d    = in_byte;
            state_d = StLo;
          end else begin
            mem_we      = 1'b1;
            ptr_d       = ptr_q + 4'd1;
            word_done_d = 1'b1;
            if (wr_count_q != CntMax) wr_count_d = wr_count_q + 5'd1;
            state_d = StHi;
          end
        end
      end
      default: state_d = StHi;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHi;
      ptr_q       <= '0;
      hi_q        <= '0;
      clr_idx_q   <= '0;
      wr_count_q  <= '0;
      word_done_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hi_q        <= hi_d;
      clr_idx_q   <= clr_idx_d;
      wr_count_q  <= wr_count_d;
      word_done_q <= word_done_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_operand2_loader.sv
// Directed bench for operand2_loader: a per-cycle vector table for the basic stream, then
// hand-written sequences for wrap, saturation, start, clear, collisions and reset.
module tb_operand2_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic [3:0]  start_addr;
  logic        clear;
  logic        busy;
  logic        word_done;
  logic [4:0]  wr_count;
  logic [3:0]  operand2_addr;
  logic [15:0] operand2_value;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] shadow [16];
  logic [3:0]  mptr;

  always #5 clk = ~clk;

  operand2_loader #(.DATA_W(16), .DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_byte        (in_byte),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .start          (start),
    .start_addr     (start_addr),
    .clear          (clear),
    .busy           (busy),
    .word_done      (word_done),
    .wr_count       (wr_count),
    .operand2_addr  (operand2_addr),
    .operand2_value (operand2_value)
  );

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic [3:0]  ra;
    logic        exp_rdy;
    logic [15:0] exp_val;
    logic        exp_wd;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bubble);
    in_valid = 1'b1;
    in_byte  = b;
    step();
    in_valid = 1'b0;
    if (bubble) step();
  endtask

  task automatic send_word(input logic [15:0] w, input bit bubble);
    send_byte(w[15:8], bubble);
    send_byte(w[7:0], bubble);
    shadow[mptr] = w;
    mptr = mptr + 4'd1;
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [15:0] exp, input string name);
    operand2_addr = a;
    step();
    chk(name, operand2_value, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    in_byte = '0; in_valid = 1'b0; start = 1'b0; start_addr = '0; clear = 1'b0;
    operand2_addr = 4'd7;
    mptr = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;

    // Stream A5 3C 12 34; each row: inputs before edge, outputs sampled after it.
    vecs[0] = '{1'b1, 8'hA5, 4'd7, 1'b1, 16'h0000, 1'b0, 5'd0};
    vecs[1] = '{1'b1, 8'h3C, 4'd0, 1'b1, 16'h0000, 1'b1, 5'd1};
    vecs[2] = '{1'b1, 8'h12, 4'd0, 1'b1, 16'hA53C, 1'b0, 5'd1};
    vecs[3] = '{1'b1, 8'h34, 4'd1, 1'b1, 16'h0000, 1'b1, 5'd2};
    vecs[4] = '{1'b0, 8'h00, 4'd1, 1'b1, 16'h1234, 1'b0, 5'd2};
    vecs[5] = '{1'b0, 8'h00, 4'd0, 1'b1, 16'hA53C, 1'b0, 5'd2};

    #12;
    chk("rst_value", operand2_value, 16'h0000);
    chk("rst_ready", 16'(in_ready), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);
    rst_n = 1'b1;
    step();
    step();
    chk("rd_addr7_after_rst", operand2_value, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      in_valid = vecs[i].v;
      in_byte = vecs[i].b;
      operand2_addr = vecs[i].ra;
      #1;
      chk($sformatf("vec%0d_ready", i), 16'(in_ready), 16'(vecs[i].exp_rdy));
      step();
      chk($sformatf("vec%0d_value", i), operand2_value, vecs[i].exp_val);
      chk($sformatf("vec%0d_wd", i), 16'(word_done), 16'(vecs[i].exp_wd));
      chk($sformatf("vec%0d_cnt", i), 16'(wr_count), 16'(vecs[i].exp_cnt));
    end
    in_valid = 1'b0;
    shadow[0] = 16'hA53C;
    shadow[1] = 16'h1234;
    mptr = 4'd2;

    // start to 15 with a byte offered in the same cycle; the byte must be refused.
    start = 1'b1; start_addr = 4'd15; in_valid = 1'b1; in_byte = 8'h99;
    #1;
    chk("start_blocks_ready", 16'(in_ready), 16'h0);
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("start_cnt_zero", 16'(wr_count), 16'h0);
    mptr = 4'd15;
    for (int i = 0; i < 4; i++) send_word(16'hC000 + 16'(i * 16'h0111), 1'b1);
    chk("wrap_cnt4", 16'(wr_count), 16'h4);
    rd_check(4'd15, 16'hC000, "wrap_addr15");
    rd_check(4'd0, 16'hC111, "wrap_addr0");
    rd_check(4'd1, 16'hC222, "wrap_addr1");
    rd_check(4'd2, 16'hC333, "wrap_addr2");

    for (int i = 0; i < 12; i++) send_word(16'h5A00 + 16'(i), 1'b0);
    chk("cnt_16", 16'(wr_count), 16'h10);
    send_word(16'h7777, 1'b0);
    chk("cnt_sat_17", 16'(wr_count), 16'h10);
    rd_check(4'd14, 16'h5A0B, "sat_addr14");
    rd_check(4'd15, 16'h7777, "sat_addr15");

    // start mid-word discards the pending FF.
    send_byte(8'hFF, 1'b0);
    start = 1'b1; start_addr = 4'd5;
    step();
    start = 1'b0;
    mptr = 4'd5;
    send_word(16'h0001, 1'b0);
    rd_check(4'd5, 16'h0001, "start_midword_addr5");
    rd_check(4'd6, shadow[6], "start_midword_addr6");

    // Bulk clear with a byte and a start issued while busy.
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", 16'(in_ready), 16'h0);
    step();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_byte = 8'hEE;
      start = (i == 3); start_addr = 4'd9;
      #1;
      chk($sformatf("clr%0d_busy", i), 16'(busy), 16'h1);
      chk($sformatf("clr%0d_ready", i), 16'(in_ready), 16'h0);
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("clr_done_busy", 16'(busy), 16'h0);
    chk("clr_done_ready", 16'(in_ready), 16'h1);
    chk("clr_done_cnt", 16'(wr_count), 16'h0);
    for (int i = 0; i < 16; i++) begin
      shadow[i] = '0;
      rd_check(4'(i), 16'h0000, $sformatf("clr_entry%0d", i));
    end
    mptr = '0;
    send_word(16'hBEEF, 1'b0);
    rd_check(4'd0, 16'hBEEF, "post_clr_addr0");
    rd_check(4'd9, 16'h0000, "post_clr_addr9");
    chk("post_clr_cnt", 16'(wr_count), 16'h1);

    // Read-before-write collision at address 3.
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    operand2_addr = 4'd3;
    send_byte(8'h33, 1'b0);
    in_valid = 1'b1; in_byte = 8'h44;
    step();
    in_valid = 1'b0;
    chk("collide_old", operand2_value, 16'h0000);
    chk("collide_wd", 16'(word_done), 16'h1);
    step();
    chk("collide_new", operand2_value, 16'h3344);

    // Reset in the middle of a clear.
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_value", operand2_value, 16'h0000);
    chk("midclr_rst_busy", 16'(busy), 16'h0);
    chk("midclr_rst_ready", 16'(in_ready), 16'h1);
    chk("midclr_rst_wd", 16'(word_done), 16'h0);
    chk("midclr_rst_cnt", 16'(wr_count), 16'h0);
    step();
    rst_n = 1'b1;
    rd_check(4'd2, 16'h0000, "after_rst_addr2");
    rd_check(4'd15, 16'h0000, "after_rst_addr15");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
